// File: rtl/bank_seq_pkg.sv
// Shared types and defaults for the bank sequence controller.
package bank_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREAMB = 3'd1,
    ST_SLOT   = 3'd2,
    ST_DONE   = 3'd3
  } state_t;

  localparam int unsigned FORCE_BIT      = 7;
  localparam int unsigned DEF_N_BANKS    = 9;
  localparam int unsigned DEF_SEQ_SLOTS  = 9;
  localparam int unsigned DEF_BANK_W     = 4;
  localparam int unsigned DEF_PREAMB_CYC = 8;

  // Reserved codes 4-7 map onto IDLE.
  function automatic state_t code_to_state(input logic [2:0] code);
    case (code)
      3'd1:    return ST_PREAMB;
      3'd2:    return ST_SLOT;
      3'd3:    return ST_DONE;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bank_onehot_dec.sv
// One-hot bank decoder; indices at or above N_BANKS yield sel=0, valid=0.
module bank_onehot_dec
  import bank_seq_pkg::*;
#(
  parameter int unsigned N_BANKS = DEF_N_BANKS,
  parameter int unsigned BANK_W  = DEF_BANK_W
) (
  input  logic [BANK_W-1:0]  idx,
  output logic [N_BANKS-1:0] sel,
  output logic               valid
);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_BANKS; i++) begin
      sel[i] = (32'(idx) == i);
    end
    valid = |sel;
  end

endmodule

// File: rtl/bank_seq_controller.sv
// Sequences the data-register bank mux through a configured slot list,
// optionally preceded by a modulation preamble, for a number of passes.
module bank_seq_controller
  import bank_seq_pkg::*;
#(
  parameter int unsigned N_BANKS    = DEF_N_BANKS,
  parameter int unsigned SEQ_SLOTS  = DEF_SEQ_SLOTS,
  parameter int unsigned BANK_W     = DEF_BANK_W,
  parameter int unsigned PREAMB_CYC = DEF_PREAMB_CYC
) (
  input  logic                           MAIN_CLK_i,
  input  logic                           N_MAIN_RST_i,
  input  logic                           FLAG_POR_i,
  input  logic                           ADD_PD_OUT_OUTFLAG_i,
  input  logic [SEQ_SLOTS*BANK_W-1:0]    CFREG_DATA_BANK_SEQUENCE_i,
  input  logic [$clog2(SEQ_SLOTS+1)-1:0] CFREG_SEQ_LENGTH_i,
  input  logic                           CFREG_DATA_SEL_SINGLE_SEQUENCE_i,
  input  logic [BANK_W-1:0]              CFREG_DATA_BANK_SELECT_i,
  input  logic [3:0]                     CFREG_DATA_BANK_REPEAT_i,
  input  logic [4:0]                     CFREG_DATA_BANK_DELAY_i,
  input  logic                           CFREG_PREAMB_i,
  input  logic                           CFREG_REPEAT_WITH_PREAMB_i,
  input  logic [7:0]                     CFREG_FORCE_STATE_FSM_i,
  output logic                           ANA_PD_EN_o,
  output logic                           ANA_MOD_EN_o,
  output logic                           ANA_INTERFACE_IN_MODSELECT_o,
  output logic                           DATA_REG_MUX_EN_o,
  output logic [N_BANKS-1:0]             DATA_REG_MUX_SEL_DATA_o,
  output logic [2:0]                     PORT_STA_LED_o,
  output logic                           SEQ_ERR_o
);

  localparam int unsigned LEN_W = $clog2(SEQ_SLOTS + 1);
  localparam int unsigned SEQ_W = SEQ_SLOTS * BANK_W;
  localparam int unsigned CNT_W = ($clog2(PREAMB_CYC) > 5) ? $clog2(PREAMB_CYC) : 5;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] slot_idx;
  logic [3:0]       pass_cnt;

  logic [SEQ_W-1:0] seq_sh;
  logic [LEN_W-1:0] last_sh;
  logic [3:0]       rep_sh;
  logic [4:0]       delay_sh;
  logic             rwp_sh;

  logic             outflag_q;
  logic             force_q;
  logic             seq_err;

  logic             force_on, release_evt, start_evt;
  logic             preamb_end, slot_end, slot_last, more_passes;
  logic [BANK_W-1:0]  bank_idx;
  logic [N_BANKS-1:0] bank_sel;
  logic               bank_valid;
  logic [SEQ_W-1:0]   seq_in;
  logic [LEN_W-1:0]   last_in;
  logic               unused_force_bits;

  assign force_on    = CFREG_FORCE_STATE_FSM_i[FORCE_BIT];
  assign release_evt = force_q & ~force_on;
  assign start_evt   = ADD_PD_OUT_OUTFLAG_i & ~outflag_q;
  assign preamb_end  = (cnt == CNT_W'(PREAMB_CYC - 1));
  assign slot_end    = (cnt == CNT_W'(delay_sh));
  assign slot_last   = (slot_idx == last_sh);
  assign more_passes = (pass_cnt < rep_sh);
  assign bank_idx    = seq_sh[slot_idx*BANK_W +: BANK_W];
  assign unused_force_bits = ^CFREG_FORCE_STATE_FSM_i[6:3];

  bank_onehot_dec #(
    .N_BANKS (N_BANKS),
    .BANK_W  (BANK_W)
  ) u_dec (
    .idx   (bank_idx),
    .sel   (bank_sel),
    .valid (bank_valid)
  );

  // Single mode is folded into the shadow as a one-slot sequence.
  always_comb begin
    seq_in  = CFREG_DATA_SEL_SINGLE_SEQUENCE_i ? SEQ_W'(CFREG_DATA_BANK_SELECT_i)
                                               : CFREG_DATA_BANK_SEQUENCE_i;
    last_in = '0;
    if (CFREG_DATA_SEL_SINGLE_SEQUENCE_i || CFREG_SEQ_LENGTH_i == '0) begin
      last_in = '0;
    end else if (32'(CFREG_SEQ_LENGTH_i) > SEQ_SLOTS) begin
      last_in = LEN_W'(SEQ_SLOTS - 1);
    end else begin
      last_in = CFREG_SEQ_LENGTH_i - LEN_W'(1);
    end
  end

  always_ff @(posedge MAIN_CLK_i or negedge N_MAIN_RST_i) begin
    if (!N_MAIN_RST_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // On force release the forced state is held one clock while counters clear.
  always_comb begin
    state_next = state;
    if (FLAG_POR_i) begin
      state_next = ST_IDLE;
    end else if (force_on) begin
      state_next = code_to_state(CFREG_FORCE_STATE_FSM_i[2:0]);
    end else if (release_evt) begin
      state_next = state;
    end else begin
      case (state)
        ST_IDLE:   if (start_evt) state_next = CFREG_PREAMB_i ? ST_PREAMB : ST_SLOT;
        ST_PREAMB: if (preamb_end) state_next = ST_SLOT;
        ST_SLOT: begin
          if (slot_end && slot_last) begin
            if (more_passes) state_next = rwp_sh ? ST_PREAMB : ST_SLOT;
            else             state_next = ST_DONE;
          end
        end
        ST_DONE:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge MAIN_CLK_i or negedge N_MAIN_RST_i) begin
    if (!N_MAIN_RST_i) begin
      cnt       <= '0;
      slot_idx  <= '0;
      pass_cnt  <= '0;
      seq_sh    <= '0;
      last_sh   <= '0;
      rep_sh    <= '0;
      delay_sh  <= '0;
      rwp_sh    <= 1'b0;
      outflag_q <= 1'b0;
      force_q   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      outflag_q <= ADD_PD_OUT_OUTFLAG_i;
      force_q   <= force_on;

      if (FLAG_POR_i) begin
        seq_err <= 1'b0;
      end else if (state == ST_SLOT && !bank_valid) begin
        seq_err <= 1'b1;
      end

      if (FLAG_POR_i || release_evt) begin
        cnt      <= '0;
        slot_idx <= '0;
        pass_cnt <= '0;
      end else if (!force_on) begin
        case (state)
          ST_IDLE: begin
            if (start_evt) begin
              cnt      <= '0;
              slot_idx <= '0;
              pass_cnt <= '0;
              seq_sh   <= seq_in;
              last_sh  <= last_in;
              rep_sh   <= CFREG_DATA_BANK_REPEAT_i;
              delay_sh <= CFREG_DATA_BANK_DELAY_i;
              rwp_sh   <= CFREG_REPEAT_WITH_PREAMB_i;
            end
          end
          ST_PREAMB: begin
            if (preamb_end) begin
              cnt      <= '0;
              slot_idx <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_SLOT: begin
            if (slot_end) begin
              cnt <= '0;
              if (slot_last) begin
                slot_idx <= '0;
                pass_cnt <= more_passes ? pass_cnt + 4'd1 : 4'd0;
              end else begin
                slot_idx <= slot_idx + LEN_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            cnt      <= '0;
            slot_idx <= '0;
            pass_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Outputs are decoded from registered state and shadow/index registers only.
  always_comb begin
    ANA_PD_EN_o                  = 1'b0;
    ANA_MOD_EN_o                 = 1'b0;
    ANA_INTERFACE_IN_MODSELECT_o = 1'b0;
    DATA_REG_MUX_EN_o            = 1'b0;
    DATA_REG_MUX_SEL_DATA_o      = '0;
    case (state)
      ST_PREAMB: begin
        ANA_PD_EN_o                  = 1'b1;
        ANA_MOD_EN_o                 = 1'b1;
        ANA_INTERFACE_IN_MODSELECT_o = 1'b1;
      end
      ST_SLOT: begin
        ANA_MOD_EN_o            = 1'b1;
        DATA_REG_MUX_EN_o       = bank_valid;
        DATA_REG_MUX_SEL_DATA_o = bank_sel;
      end
      default: ANA_PD_EN_o = 1'b1;
    endcase
  end

  assign PORT_STA_LED_o = state;
  assign SEQ_ERR_o      = seq_err;

endmodule

// File: tb/tb_bank_seq_controller.sv
// Directed test of bank_seq_controller with hand-computed expectations.
module tb_bank_seq_controller;

  logic        clk = 1'b0;
  logic        rst_n, por, outflag;
  logic [35:0] seq;
  logic [3:0]  len;
  logic        single;
  logic [3:0]  bsel;
  logic [3:0]  rep;
  logic [4:0]  dly;
  logic        preamb, rwp;
  logic [7:0]  frc;
  logic        pd, mod, modsel, mux_en, seq_err;
  logic [8:0]  sel;
  logic [2:0]  led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank_seq_controller #(
    .N_BANKS    (9),
    .SEQ_SLOTS  (9),
    .BANK_W     (4),
    .PREAMB_CYC (8)
  ) dut (
    .MAIN_CLK_i                       (clk),
    .N_MAIN_RST_i                     (rst_n),
    .FLAG_POR_i                       (por),
    .ADD_PD_OUT_OUTFLAG_i             (outflag),
    .CFREG_DATA_BANK_SEQUENCE_i       (seq),
    .CFREG_SEQ_LENGTH_i               (len),
    .CFREG_DATA_SEL_SINGLE_SEQUENCE_i (single),
    .CFREG_DATA_BANK_SELECT_i         (bsel),
    .CFREG_DATA_BANK_REPEAT_i         (rep),
    .CFREG_DATA_BANK_DELAY_i          (dly),
    .CFREG_PREAMB_i                   (preamb),
    .CFREG_REPEAT_WITH_PREAMB_i       (rwp),
    .CFREG_FORCE_STATE_FSM_i          (frc),
    .ANA_PD_EN_o                      (pd),
    .ANA_MOD_EN_o                     (mod),
    .ANA_INTERFACE_IN_MODSELECT_o     (modsel),
    .DATA_REG_MUX_EN_o                (mux_en),
    .DATA_REG_MUX_SEL_DATA_o          (sel),
    .PORT_STA_LED_o                   (led),
    .SEQ_ERR_o                        (seq_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_led"},    32'(led),    32'd0);
    check({tag, "_pd"},     32'(pd),     32'd1);
    check({tag, "_mod"},    32'(mod),    32'd0);
    check({tag, "_modsel"}, 32'(modsel), 32'd0);
    check({tag, "_muxen"},  32'(mux_en), 32'd0);
    check({tag, "_sel"},    32'(sel),    32'd0);
  endtask

  task automatic start_run();
    outflag = 1'b0;
    tick();
    outflag = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; por = 1'b0; outflag = 1'b0; seq = '0; len = '0; single = 1'b0;
    bsel = '0; rep = '0; dly = '0; preamb = 1'b0; rwp = 1'b0; frc = '0;
    tick();
    tick();
    check_idle("reset");
    check("reset_err", 32'(seq_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic four-slot run, two clocks per slot; config changes mid-run must not matter.
    seq = 36'h000003210; len = 4'd4; dly = 5'd1;
    start_run();
    for (int k = 0; k < 8; k++) begin
      check("t1_sel", 32'(sel), 32'd1 << (k / 2));
      check("t1_led", 32'(led), 32'd2);
      check("t1_muxen", 32'(mux_en), 32'd1);
      if (k == 2) begin
        dly = 5'd4; len = 4'd1; seq = '0;
      end
      tick();
    end
    check("t1_done_led", 32'(led), 32'd3);
    check("t1_done_pd", 32'(pd), 32'd1);
    check("t1_done_mod", 32'(mod), 32'd0);
    tick();
    check_idle("t1_idle");

    // Three passes each with an 8-clock preamble; outflag toggling mid-run is ignored.
    seq = 36'h54; len = 4'd2; dly = 5'd0; preamb = 1'b1; rep = 4'd2; rwp = 1'b1;
    start_run();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        check("t2_pre_led", 32'(led), 32'd1);
        check("t2_pre_modsel", 32'(modsel), 32'd1);
        check("t2_pre_muxen", 32'(mux_en), 32'd0);
        if (p == 1 && i == 0) outflag = 1'b0;
        if (p == 1 && i == 1) outflag = 1'b1;
        tick();
      end
      for (int s = 0; s < 2; s++) begin
        check("t2_slot_led", 32'(led), 32'd2);
        check("t2_slot_sel", 32'(sel), 32'd1 << (4 + s));
        check("t2_slot_modsel", 32'(modsel), 32'd0);
        tick();
      end
    end
    check("t2_done_led", 32'(led), 32'd3);
    tick();
    check_idle("t2_idle");

    // Out-of-range slot index: mux off for that slot, sticky error until POR.
    preamb = 1'b0; rep = '0; rwp = 1'b0;
    seq = 36'h3F2; len = 4'd3; dly = 5'd0;
    start_run();
    check("t3_s0_sel", 32'(sel), 32'h004);
    check("t3_s0_err", 32'(seq_err), 32'd0);
    tick();
    check("t3_bad_sel", 32'(sel), 32'd0);
    check("t3_bad_muxen", 32'(mux_en), 32'd0);
    check("t3_bad_led", 32'(led), 32'd2);
    tick();
    check("t3_s2_sel", 32'(sel), 32'h008);
    check("t3_s2_muxen", 32'(mux_en), 32'd1);
    check("t3_s2_err", 32'(seq_err), 32'd1);
    tick();
    check("t3_done_led", 32'(led), 32'd3);
    tick();
    check("t3_idle_err", 32'(seq_err), 32'd1);
    por = 1'b1;
    tick();
    por = 1'b0;
    check("t3_por_err", 32'(seq_err), 32'd0);
    tick();
    check("t3_por_err2", 32'(seq_err), 32'd0);

    // Single-bank mode ignores length and sequence.
    single = 1'b1; bsel = 4'd5; len = 4'd7; seq = 36'h111111111;
    start_run();
    bsel = 4'd3; seq = '0;
    check("t4_sel", 32'(sel), 32'h020);
    check("t4_led", 32'(led), 32'd2);
    tick();
    check("t4_done_led", 32'(led), 32'd3);
    tick();
    check_idle("t4_idle");
    single = 1'b0;

    // Length 0 behaves as 1.
    len = 4'd0; seq = 36'h6;
    start_run();
    check("t5_sel", 32'(sel), 32'h040);
    tick();
    check("t5_done_led", 32'(led), 32'd3);
    tick();

    // Length above SEQ_SLOTS clamps to 9 slots.
    len = 4'd15; seq = 36'h876543210;
    start_run();
    for (int k = 0; k < 9; k++) begin
      check("t6_sel", 32'(sel), 32'd1 << k);
      tick();
    end
    check("t6_done_led", 32'(led), 32'd3);
    tick();

    // Force SLOT mid-run freezes counters; release restarts at slot 0.
    seq = 36'h3210; len = 4'd4; dly = 5'd3;
    start_run();
    repeat (5) tick();
    check("t7_pre_sel", 32'(sel), 32'h002);
    frc = 8'h82;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t7_frc_led", 32'(led), 32'd2);
      check("t7_frc_sel", 32'(sel), 32'h002);
    end
    frc = 8'h00;
    tick();
    check("t7_rel_led", 32'(led), 32'd2);
    check("t7_rel_sel", 32'(sel), 32'h001);
    repeat (3) tick();
    check("t7_s0_sel", 32'(sel), 32'h001);
    tick();
    check("t7_s1_sel", 32'(sel), 32'h002);
    begin
      int n = 0;
      while (led !== 3'd0 && n < 40) begin
        tick();
        n++;
      end
      check("t7_end_led", 32'(led), 32'd0);
    end

    // Reserved forced code reads as IDLE; POR outranks force; bit7 gates force.
    frc = 8'h85;
    tick();
    check("t8_rsv_led", 32'(led), 32'd0);
    frc = 8'h81;
    tick();
    check("t8_pre_led", 32'(led), 32'd1);
    check("t8_pre_modsel", 32'(modsel), 32'd1);
    por = 1'b1;
    tick();
    check("t8_por_led", 32'(led), 32'd0);
    por = 1'b0; frc = 8'h03;
    tick();
    check_idle("t8_nofrc");

    // Asynchronous reset mid-slot takes effect without a clock edge.
    frc = 8'h00; seq = 36'h3210; len = 4'd4; dly = 5'd1;
    start_run();
    tick();
    check("t9_run_led", 32'(led), 32'd2);
    check("t9_run_sel", 32'(sel), 32'h001);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t9_async");
    outflag = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check_idle("t9_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
